pwm_ramp_controller: RTL and testbench
======================================

# pwm_ramp_controller

Slew-rate-limited speed sequencer for one motor channel. Accepts signed speed commands over a valid/ready handshake and steps the duty value of the downstream pulse-width modulator toward the target once per PWM period. Before reversing direction it ramps to zero and holds a dead interval. It sits between the command decoder and the PWM/H-bridge direction pin.

## Interface
- `TOP`, default 1024: PWM period in counts. Duty width is `W = $clog2(TOP)`.
- `STEP`, default 8: maximum duty change per period tick (≥1).
- `DEAD_TICKS`, default 16: period ticks held at duty 0 before a direction flip (≥1).
- `WDT_TICKS`, default 4096: watchdog timeout in period ticks. Used only with `PWM_RAMP_WATCHDOG_EN`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `period_tick` in 1: one-cycle pulse per PWM period, aligned with the PWM counter wrap.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_speed` in W+1: signed two's-complement speed target.
- `duty` out W: duty value for the PWM `value` input.
- `dir` out 1: motor direction (1 = reverse).
- `busy` out 1: state ≠ IDLE.
- `at_target` out 1: duty equals the target magnitude and dir equals the target dir.
- `wdt_expired` out 1: watchdog has fired.

## Operation
- Target register:
  - mag = |cmd_speed|, clamped to TOP-1. The most-negative input also clamps to TOP-1.
  - tdir = sign bit. Zero speed keeps the current tdir.
- States:
  - IDLE: at target.
  - RAMP: moving toward target.
  - DEAD: duty held at 0, counting.
- Transitions:
  - Command accepted with target ≠ current (mag or dir) → RAMP.
  - In RAMP, on each tick, with dir == tdir or duty == 0 and mag == 0: duty moves toward mag by min(STEP, |mag-duty|). Reaching mag → IDLE.
  - In RAMP with dir ≠ tdir and mag > 0: duty decreases by min(STEP, duty). On the tick where duty becomes 0, or if duty was already 0 → DEAD.
  - In DEAD: count DEAD_TICKS ticks. On the last tick, dir ← tdir → RAMP. Duty stays 0 on that tick.
- `cmd_ready` = 1 in IDLE and RAMP, 0 in DEAD and during reset. A command accepted in RAMP overwrites the target. Ramping continues from the current duty.
- Duty arithmetic: unsigned W bits. Never overshoots the target, never wraps below 0 or above TOP-1.
- Reset values: duty 0, dir 0, target 0/dir 0, state IDLE, busy 0, at_target 1, wdt_expired 0, dead counter 0. Reset mid-ramp or mid-DEAD aborts immediately.

## Timing
- All outputs are registered. Duty and dir update in the cycle after the `period_tick` cycle, so the PWM latches them at its next wrap.
- A command accepted in cycle N is visible in the target at N+1. `busy` rises at N+1.
- Command and `period_tick` in the same cycle: that tick steps toward the old target. The new target applies from the next tick.
- `period_tick` is ignored while `reset` is asserted.
- `at_target` and `busy` are updated in the same cycle as duty.

## Configuration
- `PWM_RAMP_WATCHDOG_EN` defined:
  - A tick counter clears on every accepted command and counts period ticks otherwise.
  - On reaching WDT_TICKS, target mag ← 0 (tdir kept), `wdt_expired` ← 1 and the counter saturates.
  - The next accepted command clears `wdt_expired`.
- Undefined: no counter is built and `wdt_expired` is tied to 0.

## Test plan
- Reset, then cmd +100, STEP=8, ticks every 16 clk:
  - duty 8,16,…,96,100 on ticks 1–13, dir 0.
  - at_target=1 and busy=0 after tick 13.
- From +100, cmd -40:
  - duty falls to 0 over 13 ticks, then DEAD with cmd_ready=0 for 16 ticks.
  - dir → 1, then duty 8…40 in 5 ticks.
- Clamp: cmd_speed -1024 (W=10) → target 1023, dir 1. cmd +2047 is not representable in W+1 bits, so use +1023 → 1023 and check no overshoot at the last step.
- Command accepted in the same cycle as period_tick during ramp to 100 at duty 48 (new target 20): that tick gives 56. Next ticks give 48, 40, … 24, 20.
- Reset asserted mid-DEAD: next cycle duty 0, dir 0, cmd_ready=0 while reset is held, cmd_ready=1 the cycle after release.
- With `PWM_RAMP_WATCHDOG_EN`, WDT_TICKS=32:
  - At target +64 with no commands, wdt_expired rises after tick 32 and duty ramps to 0 in 8 ticks.
  - A new cmd +10 clears wdt_expired.

Source files
------------

// File: rtl/pwm_ramp_controller.sv
// Slew-limited duty sequencer with ramp-to-zero and dead interval on reversal.
// Optional watchdog built when PWM_RAMP_WATCHDOG_EN is defined.
module pwm_ramp_controller #(
    parameter int TOP        = 1024,
    parameter int STEP       = 8,
    parameter int DEAD_TICKS = 16,
    parameter int WDT_TICKS  = 4096,
    localparam int W         = $clog2(TOP)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         period_tick,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W:0]   cmd_speed,
    output logic [W-1:0] duty,
    output logic         dir,
    output logic         busy,
    output logic         at_target,
    output logic         wdt_expired
);

    localparam logic [W-1:0] MAXV   = W'(TOP - 1);
    localparam logic [W:0]   STEP_W = (W+1)'(STEP);
    localparam int           DW     = $clog2(DEAD_TICKS + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEAD_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DEAD} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  duty_q, duty_d;
    logic          dir_q, dir_d;
    logic [W-1:0]  mag_q, mag_d;
    logic          tdir_q, tdir_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          ready_q, ready_d;
    logic          busy_q, at_q;
    logic          accept, fire;
    logic [W:0]    cmd_abs;
    logic [W-1:0]  cmd_mag;

    function automatic logic [W-1:0] lim(input logic [W-1:0] d);
        return ({1'b0, d} < STEP_W) ? d : STEP_W[W-1:0];
    endfunction

    assign accept  = cmd_valid & ready_q;
    // Most-negative input negates to 2^W, which the clamp folds to TOP-1
    assign cmd_abs = cmd_speed[W] ? -cmd_speed : cmd_speed;
    assign cmd_mag = (cmd_abs > {1'b0, MAXV}) ? MAXV : cmd_abs[W-1:0];

`ifdef PWM_RAMP_WATCHDOG_EN
    localparam int           CW   = $clog2(WDT_TICKS + 1);
    localparam logic [CW-1:0] WLIM = CW'(WDT_TICKS);

    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          wexp_q, wexp_d;

    always_comb begin
        wcnt_d = wcnt_q;
        wexp_d = wexp_q;
        fire   = 1'b0;
        if (accept) begin
            wcnt_d = '0;
            wexp_d = 1'b0;
        end else if (period_tick && wcnt_q != WLIM) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_d == WLIM) begin
                fire   = 1'b1;
                wexp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
            wexp_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wexp_q <= wexp_d;
        end
    end

    assign wdt_expired = wexp_q;
`else
    assign fire        = 1'b0;
    assign wdt_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        mag_d   = mag_q;
        tdir_d  = tdir_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            S_RAMP: begin
                if (period_tick) begin
                    if (dir_q == tdir_q || (duty_q == '0 && mag_q == '0)) begin
                        if (duty_q < mag_q)
                            duty_d = duty_q + lim(mag_q - duty_q);
                        else
                            duty_d = duty_q - lim(duty_q - mag_q);
                        if (duty_d == mag_q)
                            state_d = S_IDLE;
                    end else begin
                        duty_d = duty_q - lim(duty_q);
                        if (duty_d == '0) begin
                            state_d = S_DEAD;
                            dcnt_d  = '0;
                        end
                    end
                end
            end
            S_DEAD: begin
                if (period_tick) begin
                    if (dcnt_q == DLAST) begin
                        dir_d   = tdir_q;
                        dcnt_d  = '0;
                        state_d = S_RAMP;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (fire)
            mag_d = '0;
        if (accept) begin
            mag_d = cmd_mag;
            if (cmd_speed != '0)
                tdir_d = cmd_speed[W];
        end
        // A new target re-decides idle vs ramp; DEAD always runs to completion
        if ((accept || fire) && state_d != S_DEAD)
            state_d = (mag_d == duty_d && tdir_d == dir_d) ? S_IDLE : S_RAMP;
        ready_d = (state_d != S_DEAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            mag_q   <= '0;
            tdir_q  <= 1'b0;
            dcnt_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            at_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            mag_q   <= mag_d;
            tdir_q  <= tdir_d;
            dcnt_q  <= dcnt_d;
            ready_q <= ready_d;
            busy_q  <= (state_d != S_IDLE);
            at_q    <= (duty_d == mag_d) && (dir_d == tdir_d);
        end
    end

    assign cmd_ready = ready_q;
    assign duty      = duty_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign at_target = at_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed and randomized bench for pwm_ramp_controller against an
// integer reference model of the ramp/dead/watchdog rules.
module tb_pwm_ramp_controller;

    localparam int TOP  = 1024;
    localparam int W    = 10;
    localparam int STEP = 8;
    localparam int DEAD = 16;
    localparam int WDT  = 32;
`ifdef PWM_RAMP_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         period_tick = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W:0]   cmd_speed = '0;
    logic [W-1:0] duty;
    logic         dir, busy, at_target, wdt_expired;

    int vectors = 0;
    int miscompares = 0;

    int m_duty, m_dir, m_mag, m_tdir, m_mode, m_dc, m_ready, m_wc, m_wexp;

    pwm_ramp_controller #(
        .TOP(TOP), .STEP(STEP), .DEAD_TICKS(DEAD), .WDT_TICKS(WDT)
    ) dut (
        .clk(clk), .reset(reset), .period_tick(period_tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_speed(cmd_speed),
        .duty(duty), .dir(dir), .busy(busy), .at_target(at_target),
        .wdt_expired(wdt_expired)
    );

    always #5 clk = ~clk;

    // mode: 0 at target, 1 moving, 2 dead interval
    task automatic model(input bit r, input bit t, input bit v, input int s);
        bit acc, fire;
        int d;
        if (r) begin
            m_duty = 0; m_dir = 0; m_mag = 0; m_tdir = 0; m_mode = 0;
            m_dc = 0; m_ready = 0; m_wc = 0; m_wexp = 0;
            return;
        end
        acc  = v && (m_ready != 0);
        fire = 1'b0;
        if (t) begin
            if (m_mode == 1) begin
                if (m_dir == m_tdir || (m_duty == 0 && m_mag == 0)) begin
                    d = m_mag - m_duty;
                    if (d > STEP) d = STEP;
                    if (d < -STEP) d = -STEP;
                    m_duty += d;
                    if (m_duty == m_mag) m_mode = 0;
                end else begin
                    m_duty -= (m_duty < STEP) ? m_duty : STEP;
                    if (m_duty == 0) begin m_mode = 2; m_dc = 0; end
                end
            end else if (m_mode == 2) begin
                m_dc++;
                if (m_dc == DEAD) begin m_dir = m_tdir; m_mode = 1; m_dc = 0; end
            end
        end
        if (WDT_ON) begin
            if (acc) begin
                m_wc = 0; m_wexp = 0;
            end else if (t && m_wc < WDT) begin
                m_wc++;
                if (m_wc == WDT) begin m_mag = 0; m_wexp = 1; fire = 1'b1; end
            end
        end
        if (acc) begin
            m_mag = (s < 0) ? -s : s;
            if (m_mag > TOP - 1) m_mag = TOP - 1;
            if (s != 0) m_tdir = (s < 0) ? 1 : 0;
        end
        if ((acc || fire) && m_mode != 2)
            m_mode = (m_mag == m_duty && m_tdir == m_dir) ? 0 : 1;
        m_ready = (m_mode != 2) ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("duty", 32'(duty), m_duty);
        chk("dir", 32'(dir), m_dir);
        chk("busy", 32'(busy), (m_mode != 0) ? 1 : 0);
        chk("at_target", 32'(at_target), (m_duty == m_mag && m_dir == m_tdir) ? 1 : 0);
        chk("cmd_ready", 32'(cmd_ready), m_ready);
        chk("wdt_expired", 32'(wdt_expired), m_wexp);
    endtask

    task automatic step(input bit t, input bit v, input int s);
        logic [31:0] sv;
        sv = 32'(s);
        period_tick = t;
        cmd_valid   = v;
        cmd_speed   = sv[W:0];
        @(posedge clk);
        model(reset, t, v, s);
        #1;
        period_tick = 1'b0;
        cmd_valid   = 1'b0;
        check_all();
    endtask

    task automatic ticks(input int n, input int p);
        repeat (n) begin
            repeat (p - 1) step(1'b0, 1'b0, 0);
            step(1'b1, 1'b0, 0);
        end
    endtask

    task automatic cmd(input int s);
        step(1'b0, 1'b1, s);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        reset = 1'b0;
        step(1'b0, 1'b0, 0);
    endtask

    initial begin
        model(1'b1, 1'b0, 1'b0, 0);
        // reset state
        reset = 1'b1;
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_at_target", 32'(at_target), 1);
        reset = 1'b0;
        step(1'b0, 1'b0, 0);
        chk("rel_ready", 32'(cmd_ready), 1);

        // ramp up to +100
        cmd(100);
        chk("busy_rise", 32'(busy), 1);
        ticks(12, 16);
        chk("ramp_96", 32'(duty), 96);
        ticks(1, 16);
        chk("ramp_100", 32'(duty), 100);
        chk("ramp_done_busy", 32'(busy), 0);
        chk("ramp_done_at", 32'(at_target), 1);

        // reversal to -40
        cmd(-40);
        ticks(13, 16);
        chk("rev_zero", 32'(duty), 0);
        chk("rev_dead_ready", 32'(cmd_ready), 0);
        ticks(15, 16);
        chk("rev_dead_dir", 32'(dir), 0);
        ticks(1, 16);
        chk("rev_dir", 32'(dir), 1);
        ticks(5, 16);
        chk("rev_40", 32'(duty), 40);
        chk("rev_at", 32'(at_target), 1);

        // clamps
        cmd(-1024);
        ticks(123, 2);
        chk("clamp_neg", 32'(duty), 1023);
        chk("clamp_neg_dir", 32'(dir), 1);
        cmd(1023);
        ticks(271, 2);
        chk("clamp_pos_1016", 32'(duty), 1016);
        ticks(1, 2);
        chk("clamp_pos", 32'(duty), 1023);
        chk("clamp_pos_dir", 32'(dir), 0);

        // command coincident with tick
        do_reset();
        cmd(100);
        ticks(6, 4);
        chk("coin_48", 32'(duty), 48);
        step(1'b1, 1'b1, 20);
        chk("coin_56", 32'(duty), 56);
        ticks(1, 4);
        chk("coin_back_48", 32'(duty), 48);
        ticks(4, 4);
        chk("coin_20", 32'(duty), 20);
        chk("coin_idle", 32'(busy), 0);

        // reset mid-DEAD with dir reversed
        cmd(-40);
        ticks(24, 4);
        chk("pre_dir", 32'(dir), 1);
        cmd(40);
        ticks(9, 4);
        chk("mid_dead_ready", 32'(cmd_ready), 0);
        reset = 1'b1;
        step(1'b0, 1'b0, 0);
        chk("mid_rst_dir", 32'(dir), 0);
        chk("mid_rst_duty", 32'(duty), 0);
        step(1'b1, 1'b0, 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        reset = 1'b0;
        step(1'b0, 1'b0, 0);
        chk("mid_rel_ready", 32'(cmd_ready), 1);

`ifdef PWM_RAMP_WATCHDOG_EN
        cmd(64);
        ticks(8, 4);
        chk("wdt_64", 32'(duty), 64);
        ticks(23, 4);
        chk("wdt_not_yet", 32'(wdt_expired), 0);
        ticks(1, 4);
        chk("wdt_fire", 32'(wdt_expired), 1);
        ticks(8, 4);
        chk("wdt_zero", 32'(duty), 0);
        cmd(10);
        chk("wdt_clear", 32'(wdt_expired), 0);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r, s;
            bit t, v;
            reset = ($urandom_range(0, 999) == 0);
            t = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 9);
            if (r == 0) s = int'($urandom_range(0, 2047)) - 1024;
            else if (r == 1) s = 0;
            else s = int'($urandom_range(0, 160)) - 80;
            step(t, v, s);
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
